// File: rtl/spi_sched_pkg.sv
// Shared types and sizing helpers for the SPI transfer scheduler.
// Holds the frame sequencer state enum, the SHIFT-phase length and the CS-index width.
package spi_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  function automatic int frame_len(input int clk_div, input int dat_width);
    return 2 * clk_div * dat_width;
  endfunction

  function automatic int cs_width(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant to the first request at/after the pointer.
// Zero latency grant; pointer moves past the winner only on a cycle where the grant is accepted.
module spi_rr_arbiter
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr_q, ptr_d, win;
  logic [PTR_W:0]   sum;

  always_comb begin
    win = ptr_q;
    sum = '0;
    // Scan from farthest to nearest so the nearest requester at/after the pointer wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      if (req_i[sum[PTR_W-1:0]]) win = sum[PTR_W-1:0];
    end
    gnt_o = '0;
    if (|req_i) gnt_o[win] = 1'b1;
    ptr_d = ptr_q;
    if (accept_i && |req_i) ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Shares one SPI mode-0 link among NUM_REQ requesters; grant to done = 1+CLK_DIV*(2+2*DAT_WIDTH) cycles.
// Requests are levels held until gnt_o; no new grant is issued until the frame and CS gap finish.
module spi_xfer_scheduler
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DAT_WIDTH = 8,
  parameter int NUM_CS    = 4,
  parameter int CS_W      = cs_width(NUM_CS),
  parameter int CLK_DIV   = 2,
  parameter int CS_GAP    = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*CS_W-1:0]      req_cs_i,
  input  logic [NUM_REQ*DAT_WIDTH-1:0] req_dat_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [NUM_REQ-1:0]           done_o,
  output logic [DAT_WIDTH-1:0]         rx_dat_o,
  output logic                         busy_o,
  output logic                         sck_o,
  output logic [NUM_CS-1:0]            csn_o,
  output logic                         mosi_o,
  input  logic                         miso_i
);

  localparam int FRAME   = frame_len(CLK_DIV, DAT_WIDTH);
  localparam int CNT_MAX = (FRAME > CS_GAP) ? FRAME : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(CLK_DIV + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DAT_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rx_dat_q, rx_dat_d;
  logic [CS_W-1:0]      cs_q, cs_d;
  logic [NUM_REQ-1:0]   own_q, own_d, done_q, done_d, arb_gnt;
  logic [NUM_CS-1:0]    csn_q, csn_d;
  logic                 sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d;

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .req_i     (req_i),
    .accept_i  (state_q == IDLE),
    .gnt_o     (arb_gnt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    div_d    = div_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    cs_d     = cs_q;
    own_d    = own_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    csn_d    = csn_q;
    busy_d   = busy_q;
    done_d   = '0;
    rx_dat_d = rx_dat_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req_i) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) begin
              cs_d = req_cs_i[k*CS_W +: CS_W];
              tx_d = req_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
            end
          end
          state_d     = SETUP;
          own_d       = arb_gnt;
          mosi_d      = tx_d[DAT_WIDTH-1];
          csn_d       = '1;
          csn_d[cs_d] = 1'b0;
          busy_d      = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          div_d   = '0;
          sck_d   = 1'b1;
        end
      end
      SHIFT: begin
        // The final cycle is always the low half of the last bit, so no edge is lost here.
        if (cnt_q == CNT_W'(FRAME - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
          sck_d   = 1'b0;
        end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (sck_q) begin
            rx_d   = {rx_q[DAT_WIDTH-2:0], miso_i};
            tx_d   = {tx_q[DAT_WIDTH-2:0], 1'b0};
            mosi_d = tx_d[DAT_WIDTH-1];
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d  = GAP;
          cnt_d    = '0;
          csn_d    = '1;
          done_d   = own_q;
          rx_dat_d = rx_q;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(CS_GAP - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      cs_q     <= '0;
      own_q    <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      csn_q    <= '1;
      busy_q   <= 1'b0;
      done_q   <= '0;
      rx_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      cs_q     <= cs_d;
      own_q    <= own_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      csn_q    <= csn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rx_dat_q <= rx_dat_d;
    end
  end

  assign gnt_o    = (state_q == IDLE) ? arb_gnt : '0;
  assign done_o   = done_q;
  assign rx_dat_o = rx_dat_q;
  assign busy_o   = busy_q;
  assign sck_o    = sck_q;
  assign csn_o    = csn_q;
  assign mosi_o   = mosi_q;

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Directed bench: default build plus a CLK_DIV=1, DAT_WIDTH=16 build, each with an echoing SPI target.
module tb_spi_xfer_scheduler;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  always #5 clk_i = ~clk_i;

  // Default build
  logic [3:0]  req_i, gnt_o, done_o, csn_o;
  logic [7:0]  req_cs_i, rx_dat_o;
  logic [31:0] req_dat_i;
  logic        busy_o, sck_o, mosi_o, miso_i;

  // CLK_DIV=1, DAT_WIDTH=16 build
  logic [3:0]  req16, gnt16, done16, csn16;
  logic [7:0]  cs16;
  logic [63:0] dat16;
  logic [15:0] rx16;
  logic        busy16, sck16, mosi16, miso16;

  int checks = 0;
  int errors = 0;

  spi_xfer_scheduler dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .req_i(req_i), .req_cs_i(req_cs_i),
    .req_dat_i(req_dat_i), .gnt_o(gnt_o), .done_o(done_o), .rx_dat_o(rx_dat_o),
    .busy_o(busy_o), .sck_o(sck_o), .csn_o(csn_o), .mosi_o(mosi_o), .miso_i(miso_i)
  );

  spi_xfer_scheduler #(.DAT_WIDTH(16), .CLK_DIV(1)) dut16 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .req_i(req16), .req_cs_i(cs16),
    .req_dat_i(dat16), .gnt_o(gnt16), .done_o(done16), .rx_dat_o(rx16),
    .busy_o(busy16), .sck_o(sck16), .csn_o(csn16), .mosi_o(mosi16), .miso_i(miso16)
  );

  // SPI targets: shift echo word out MSB first, advance on SCK fall, capture MOSI while SCK high.
  logic [7:0]  echo8, t_sreg, t_mosi;
  int          t_pulses, t_high;
  logic        t_prev;
  assign miso_i = t_sreg[7];
  always @(posedge clk_i) begin
    if (&csn_o) begin
      t_sreg <= echo8; t_mosi <= '0; t_pulses <= 0; t_high <= 0;
    end else begin
      if (t_prev && !sck_o) t_sreg <= {t_sreg[6:0], 1'b0};
      if (!t_prev && sck_o) begin t_mosi <= {t_mosi[6:0], mosi_o}; t_pulses <= t_pulses + 1; end
      if (sck_o) t_high <= t_high + 1;
    end
    t_prev <= sck_o;
  end

  logic [15:0] echo16, u_sreg, u_mosi;
  int          u_pulses, u_high;
  logic        u_prev;
  assign miso16 = u_sreg[15];
  always @(posedge clk_i) begin
    if (&csn16) begin
      u_sreg <= echo16; u_mosi <= '0; u_pulses <= 0; u_high <= 0;
    end else begin
      if (u_prev && !sck16) u_sreg <= {u_sreg[14:0], 1'b0};
      if (!u_prev && sck16) begin u_mosi <= {u_mosi[14:0], mosi16}; u_pulses <= u_pulses + 1; end
      if (sck16) u_high <= u_high + 1;
    end
    u_prev <= sck16;
  end

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  cs_all;   // {cs3, cs2, cs1, cs0}
    logic [31:0] dat_all;  // {dat3, dat2, dat1, dat0}
    logic [7:0]  echo;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_csn;
    logic [7:0]  exp_mosi;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic wait_gnt(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (gnt_o != '0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 200) begin tick(); n++; end
    check(name, busy_o, 1'b0);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    tick(); tick();
    reset_n_i = 1'b1;
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    logic ok;
    int   n;
    echo8 = v.echo; req_cs_i = v.cs_all; req_dat_i = v.dat_all; req_i = v.req;
    wait_gnt(ok);
    check({tag, " gnt_seen"}, ok, 1'b1);
    check({tag, " gnt"}, gnt_o, v.exp_gnt);
    tick();
    req_i = '0; req_cs_i = ~v.cs_all; req_dat_i = ~v.dat_all;
    check({tag, " csn_t1"}, csn_o, v.exp_csn);
    check({tag, " busy_t1"}, busy_o, 1'b1);
    n = 1;
    while (done_o == '0 && n < 100) begin tick(); n++; end
    check({tag, " latency"}, n, 37);
    check({tag, " done"}, done_o, v.exp_gnt);
    check({tag, " rx_dat"}, rx_dat_o, v.echo);
    check({tag, " csn_done"}, csn_o, 4'hF);
    check({tag, " mosi_word"}, t_mosi, v.exp_mosi);
    check({tag, " sck_pulses"}, t_pulses, 8);
    check({tag, " sck_high_cycles"}, t_high, 16);
  endtask

  task automatic test_rr_all();
    int gcyc[5], gidx[5];
    int ng = 0;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    req_cs_i = '0; req_dat_i = '0; echo8 = '0; req_i = 4'hF;
    for (int c = 0; c < 400 && ng < 5; c++) begin
      #1;
      if (gnt_o != '0) begin gcyc[ng] = c; gidx[ng] = oh2idx(gnt_o); ng++; end
      tick();
    end
    req_i = '0;
    check("rr_all grant_count", ng, 5);
    for (int i = 0; i < ng; i++) begin
      check($sformatf("rr_all order%0d", i), gidx[i], exp_order[i]);
      if (i > 0) check($sformatf("rr_all spacing%0d", i), gcyc[i] - gcyc[i-1], 39);
    end
    wait_idle("rr_all idle");
  endtask

  task automatic test_rerequest();
    logic       ok;
    logic [3:0] g;
    int         n = 0;
    int         ng = 0;
    int         gidx[3];
    int         exp_order[3] = '{3, 0, 2};
    req_i = 4'b0100;
    wait_gnt(ok);
    check("rereq first_gnt", gnt_o, 4'b0100);
    tick();
    req_i = 4'b1001;
    while (!done_o[2] && n < 100) begin tick(); n++; end
    check("rereq done2", done_o, 4'b0100);
    req_i = req_i | 4'b0100;
    for (int c = 0; c < 400 && ng < 3; c++) begin
      #1;
      g = gnt_o;
      if (g != '0) begin gidx[ng] = oh2idx(g); ng++; end
      tick();
      req_i = req_i & ~g;
    end
    req_i = '0;
    check("rereq grant_count", ng, 3);
    for (int i = 0; i < ng; i++) check($sformatf("rereq order%0d", i), gidx[i], exp_order[i]);
    wait_idle("rereq idle");
  endtask

  task automatic test_reset_mid();
    logic ok;
    echo8 = 8'h3C; req_cs_i = {2'd0, 2'd0, 2'd0, 2'd2}; req_dat_i = 32'h0000_00A5; req_i = 4'b0001;
    wait_gnt(ok);
    check("rst_mid gnt", gnt_o, 4'b0001);
    tick();
    req_i = '0;
    repeat (19) tick();
    check("rst_mid in_shift_busy", busy_o, 1'b1);
    reset_n_i = 1'b0;
    #1;
    check("rst_mid csn", csn_o, 4'hF);
    check("rst_mid sck", sck_o, 1'b0);
    check("rst_mid busy", busy_o, 1'b0);
    check("rst_mid rx_dat", rx_dat_o, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_mid no_done%0d", i), done_o, 4'b0000);
    end
    reset_n_i = 1'b1;
  endtask

  task automatic test_wide();
    int n = 0;
    echo16 = 16'h1234;
    cs16   = {2'd0, 2'd3, 2'd1, 2'd2};
    dat16  = {16'h0000, 16'hBEEF, 16'h1111, 16'h2222};
    req16  = 4'b0100;
    #1;
    while (gnt16 == '0 && n < 100) begin tick(); n++; end
    check("w16 gnt", gnt16, 4'b0100);
    tick();
    req16 = '0; dat16 = '1; cs16 = '0;
    check("w16 csn_t1", csn16, 4'b0111);
    check("w16 busy_t1", busy16, 1'b1);
    n = 1;
    while (done16 == '0 && n < 100) begin tick(); n++; end
    check("w16 latency", n, 35);
    check("w16 done", done16, 4'b0100);
    check("w16 rx_dat", rx16, 16'h1234);
    check("w16 mosi_word", u_mosi, 16'hBEEF);
    check("w16 sck_pulses", u_pulses, 16);
    check("w16 sck_high_cycles", u_high, 16);
  endtask

  initial begin
    vecs[0] = '{4'b0001, {2'd0, 2'd1, 2'd3, 2'd2}, {8'h11, 8'h22, 8'h33, 8'hA5}, 8'h3C, 4'b0001, 4'hB, 8'hA5};
    vecs[1] = '{4'b0001, {2'd1, 2'd2, 2'd3, 2'd0}, {8'h77, 8'hFF, 8'h00, 8'h5A}, 8'hC3, 4'b0001, 4'hE, 8'h5A};
    vecs[2] = '{4'b1001, {2'd3, 2'd0, 2'd0, 2'd0}, {8'hFF, 8'h12, 8'h34, 8'h56}, 8'h00, 4'b1000, 4'h7, 8'hFF};
    vecs[3] = '{4'b0110, {2'd0, 2'd3, 2'd1, 2'd2}, {8'hAA, 8'hBB, 8'h00, 8'hCC}, 8'hFF, 4'b0010, 4'hD, 8'h00};
    vecs[4] = '{4'b0111, {2'd1, 2'd2, 2'd0, 2'd3}, {8'h01, 8'h81, 8'h02, 8'h03}, 8'h7E, 4'b0100, 4'hB, 8'h81};
    vecs[5] = '{4'b0011, {2'd2, 2'd2, 2'd3, 2'd0}, {8'h44, 8'h55, 8'h66, 8'h6C}, 8'h93, 4'b0001, 4'hE, 8'h6C};

    reset_n_i = 1'b0;
    req_i = '0; req_cs_i = '0; req_dat_i = '0; echo8 = '0;
    req16 = '0; cs16 = '0; dat16 = '0; echo16 = '0;
    tick(); tick();
    reset_n_i = 1'b1;
    tick();

    check("rst gnt", gnt_o, 4'b0000);
    check("rst done", done_o, 4'b0000);
    check("rst rx_dat", rx_dat_o, 8'h00);
    check("rst mosi", mosi_o, 1'b0);
    check("rst csn16", csn16, 4'hF);

    for (int c = 0; c < 50; c++) begin
      check($sformatf("idle c%0d {csn,sck,gnt,busy}", c), {csn_o, sck_o, gnt_o, busy_o}, {4'hF, 1'b0, 4'b0000, 1'b0});
      tick();
    end

    for (int i = 0; i < 6; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));
    wait_idle("vec idle");

    test_reset_mid();
    run_xfer('{4'b0010, {2'd0, 2'd0, 2'd1, 2'd0}, {8'h00, 8'h00, 8'h96, 8'h00}, 8'h5B, 4'b0010, 4'hD, 8'h96}, "post_rst");
    wait_idle("post_rst idle");

    do_reset();
    test_rr_all();
    test_rerequest();
    test_wide();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
